// File: rtl/pipeline_ctrl_if.sv
// Hazard/memory request inputs and per-stage load/bubble controls
// exchanged between the hazard unit, data memory and pipeline_ctrl.
//   master: drives hazard/memory requests, receives stage controls
//   slave : the controller; consumes requests, drives stage controls
interface pipeline_ctrl_if;
    logic stall_ifid;
    logic stall_idex;
    logic flush_ifid;
    logic dmem_req;
    logic dmem_ready;
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_bubble;
    logic memwb_bubble;

    modport master (
        output stall_ifid, stall_idex, flush_ifid,
        output dmem_req, dmem_ready,
        input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
        input  ifid_flush, idex_bubble, exmem_bubble, memwb_bubble
    );

    modport slave (
        input  stall_ifid, stall_idex, flush_ifid,
        input  dmem_req, dmem_ready,
        output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
        output ifid_flush, idex_bubble, exmem_bubble, memwb_bubble
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: turns hazard and data-memory wait
// requests into register write-enables and bubble/flush controls.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : hazard/memory requests in, stage controls out
//   state        : IDLE=0, RUN=1, MWAIT=2
//   mem_err      : sticky memory-wait timeout flag
//   retired_cnt  : saturating count of instructions leaving MEM/WB
//   stall_cnt    : saturating count of cycles with the PC held
module pipeline_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.slave   bus,
    output logic [1:0]       state,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        MWAIT = 2'd2
    } state_t;

    localparam int MW_LOG = $clog2(MEM_TIMEOUT + 1);
    localparam int MW_W   = (MW_LOG > 4) ? MW_LOG : 4;
    localparam logic [MW_W-1:0]  MW_MAX  = MW_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t          state_q, state_d;
    logic [MW_W-1:0] mwait_q, mwait_d;
    logic            err_set;
    logic            v_ifid, v_idex, v_exmem, v_memwb;

    logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic ifid_flush, idex_bubble, exmem_bubble, memwb_bubble;

    always_comb begin
        state_d      = state_q;
        mwait_d      = mwait_q;
        err_set      = 1'b0;
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        idex_we      = 1'b0;
        exmem_we     = 1'b0;
        memwb_we     = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        memwb_bubble = 1'b0;

        unique case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                // Memory wait outranks load-use stalls, which outrank
                // the flush; a flush lost here is re-presented upstream.
                if (bus.dmem_req && !bus.dmem_ready) begin
                    memwb_we     = 1'b1;
                    memwb_bubble = 1'b1;
                    state_d      = MWAIT;
                    mwait_d      = MW_W'(1);
                end else if (bus.stall_idex) begin
                    exmem_we     = 1'b1;
                    exmem_bubble = 1'b1;
                    memwb_we     = 1'b1;
                end else if (bus.stall_ifid) begin
                    idex_we     = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_we    = 1'b1;
                    memwb_we    = 1'b1;
                end else begin
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    idex_we    = 1'b1;
                    exmem_we   = 1'b1;
                    memwb_we   = 1'b1;
                    ifid_flush = bus.flush_ifid;
                end
            end
            MWAIT: begin
                if (bus.dmem_ready || mwait_q == MW_MAX) begin
                    pc_we    = 1'b1;
                    ifid_we  = 1'b1;
                    idex_we  = 1'b1;
                    exmem_we = 1'b1;
                    memwb_we = 1'b1;
                    err_set  = !bus.dmem_ready;
                    state_d  = RUN;
                end else begin
                    memwb_we     = 1'b1;
                    memwb_bubble = 1'b1;
                    mwait_d      = mwait_q + MW_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_we     = 1'b0;
            ifid_flush   = 1'b0;
            idex_bubble  = 1'b0;
            exmem_bubble = 1'b0;
            memwb_bubble = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mwait_q     <= '0;
            mem_err     <= 1'b0;
            v_ifid      <= 1'b0;
            v_idex      <= 1'b0;
            v_exmem     <= 1'b0;
            v_memwb     <= 1'b0;
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            state_q <= state_d;
            mwait_q <= mwait_d;
            if (err_set)
                mem_err <= 1'b1;
            if (ifid_we)
                v_ifid <= !ifid_flush;
            if (idex_we)
                v_idex <= v_ifid && !idex_bubble;
            if (exmem_we)
                v_exmem <= v_idex && !exmem_bubble;
            if (memwb_we)
                v_memwb <= v_exmem && !memwb_bubble;
            if (v_memwb && state_q != IDLE && retired_cnt != CNT_MAX)
                retired_cnt <= retired_cnt + CNT_W'(1);
            if (!pc_we && (state_q == RUN || state_q == MWAIT) &&
                stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign state            = state_q;
    assign bus.pc_we        = pc_we;
    assign bus.ifid_we      = ifid_we;
    assign bus.idex_we      = idex_we;
    assign bus.exmem_we     = exmem_we;
    assign bus.memwb_we     = memwb_we;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_bubble  = idex_bubble;
    assign bus.exmem_bubble = exmem_bubble;
    assign bus.memwb_bubble = memwb_bubble;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a stall-point model of the pipe
// predicts each cycle; a negedge monitor compares two DUT widths.
module tb_pipeline_ctrl;

    localparam int TMO = 15;

    typedef struct {
        logic [8:0] ctrl;
        logic [1:0] st;
        logic       err;
        int         ret;
        int         stl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_ctrl_if bus ();
    pipeline_ctrl_if sbus ();

    assign sbus.stall_ifid = bus.stall_ifid;
    assign sbus.stall_idex = bus.stall_idex;
    assign sbus.flush_ifid = bus.flush_ifid;
    assign sbus.dmem_req   = bus.dmem_req;
    assign sbus.dmem_ready = bus.dmem_ready;

    logic [1:0]  state, s_state;
    logic        mem_err, s_mem_err;
    logic [15:0] retired_cnt, stall_cnt;
    logic [3:0]  s_retired, s_stall;

    pipeline_ctrl #(.CNT_W(16), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .state(state), .mem_err(mem_err),
        .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
    );

    pipeline_ctrl #(.CNT_W(4), .MEM_TIMEOUT(TMO)) dut_sat (
        .clk(clk), .rst(rst), .bus(sbus),
        .state(s_state), .mem_err(s_mem_err),
        .retired_cnt(s_retired), .stall_cnt(s_stall)
    );

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Model: mode 0 idle, 1 run, 2 wait; v[1..4] stage valids.
    int mode = 0;
    int wn = 0;
    bit err = 1'b0;
    int ret = 0;
    int stl = 0;
    bit v[1:4] = '{default: 1'b0};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     name, cyc, act, expv);
        end
    endtask

    function automatic int sat(input int x, input int mx);
        return (x > mx) ? mx : x;
    endfunction

    task automatic step(input bit r, input bit sif, input bit sex,
                        input bit fl, input bit req, input bit rdy);
        exp_t e;
        int   k;
        bit   fla;
        bit   we[5];
        @(posedge clk);
        #1;
        rst            = r;
        bus.stall_ifid = sif;
        bus.stall_idex = sex;
        bus.flush_ifid = fl;
        bus.dmem_req   = req;
        bus.dmem_ready = rdy;
        // k is the stall point: stages before k hold, stage k takes
        // a bubble, stages after k advance; k=5 means nothing loads.
        fla = 1'b0;
        if (r || mode == 0)
            k = 5;
        else if (mode == 1) begin
            if (req && !rdy)
                k = 4;
            else if (sex)
                k = 3;
            else if (sif)
                k = 2;
            else begin
                k   = 0;
                fla = fl;
            end
        end else
            k = (rdy || wn == TMO) ? 0 : 4;
        for (int i = 0; i < 5; i++)
            we[i] = (i >= k);
        e.ctrl = {we[0], we[1], we[2], we[3], we[4],
                  fla, k == 2, k == 3, k == 4};
        e.st   = 2'(mode);
        e.err  = err;
        e.ret  = ret;
        e.stl  = stl;
        q.push_back(e);

        if (r) begin
            mode = 0;
            wn   = 0;
            err  = 1'b0;
            ret  = 0;
            stl  = 0;
            v    = '{default: 1'b0};
        end else begin
            if (mode != 0 && !we[0])
                stl++;
            if (mode != 0 && v[4])
                ret++;
            for (int i = 4; i >= 1; i--)
                if (we[i])
                    v[i] = (i == k) ? 1'b0 :
                           (i == 1) ? !fla : v[i-1];
            if (mode == 0)
                mode = 1;
            else if (mode == 1) begin
                if (k == 4) begin
                    mode = 2;
                    wn   = 1;
                end
            end else if (k == 0) begin
                if (!rdy)
                    err = 1'b1;
                mode = 1;
            end else
                wn++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ctrl", 32'({bus.pc_we, bus.ifid_we,
                    bus.idex_we, bus.exmem_we, bus.memwb_we,
                    bus.ifid_flush, bus.idex_bubble,
                    bus.exmem_bubble, bus.memwb_bubble}),
                    32'(e.ctrl));
                chk("state", 32'(state), 32'(e.st));
                chk("mem_err", 32'(mem_err), 32'(e.err));
                chk("retired", 32'(retired_cnt),
                    32'(sat(e.ret, 65535)));
                chk("stall", 32'(stall_cnt),
                    32'(sat(e.stl, 65535)));
                chk("sat_retired", 32'(s_retired),
                    32'(sat(e.ret, 15)));
                chk("sat_stall", 32'(s_stall),
                    32'(sat(e.stl, 15)));
            end
        end
    end

    initial begin
        bus.stall_ifid = 1'b0;
        bus.stall_idex = 1'b0;
        bus.flush_ifid = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.dmem_ready = 1'b0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(8);

        step(0, 0, 1, 0, 0, 0);
        idle(5);

        step(0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(3);

        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        idle(3);

        step(0, 0, 0, 0, 1, 1);
        idle(2);

        for (int i = 0; i < 20; i++)
            step(0, 1, 1, 1, 1, 0);
        idle(4);

        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        idle(4);

        for (int i = 0; i < 40; i++)
            step(0, 0, 1, 0, 0, 0);
        idle(4);

        for (int n = 0; n < 2000; n++)
            step($urandom_range(199) == 0,
                 $urandom_range(7) == 0,
                 $urandom_range(7) == 0,
                 $urandom_range(5) == 0,
                 $urandom_range(3) == 0,
                 $urandom_range(2) == 0);
        idle(2);

        @(negedge clk);
        #1;
        chk("drain", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
